// File: rtl/oled_text_console_pkg.sv
// Shared definitions for the OLED text console: FSM codes, ASCII
// constants, screen geometry and cursor operation codes.
package oled_text_console_pkg;

  typedef enum logic [2:0] {
    S_OFF,
    S_ON_WAIT,
    S_IDLE,
    S_WR,
    S_WR_WAIT,
    S_CLR,
    S_CLR_WAIT,
    S_UPD_WAIT
  } state_e;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_FF    = 8'h0C;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] PRINT_LO    = 8'h20;
  localparam logic [7:0] PRINT_HI    = 8'h7E;

  localparam int ROWS = 4;
  localparam int COLS = 16;

  localparam logic [2:0] CUR_NONE = 3'd0;
  localparam logic [2:0] CUR_INC  = 3'd1;
  localparam logic [2:0] CUR_LF   = 3'd2;
  localparam logic [2:0] CUR_CR   = 3'd3;
  localparam logic [2:0] CUR_BS   = 3'd4;
  localparam logic [2:0] CUR_HOME = 3'd5;

  function automatic logic is_print(
    input logic [7:0] c
  );
    return (c >= PRINT_LO) && (c <= PRINT_HI);
  endfunction

endpackage

// File: rtl/oled_text_console_cursor.sv
// Text cursor {row, col} for the console: next-position decode for
// printable, LF, CR, BS and home, registered on the clock.
module oled_cursor
  import oled_text_console_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] op,
  output logic [5:0] cursor
);

  localparam int CB = $clog2(COLS);
  localparam int RB = $clog2(ROWS);

  logic [5:0] nxt;
  logic [RB-1:0] row;

  assign row = cursor[RB+CB-1:CB];

  always_comb begin
    nxt = cursor;
    case (op)
      CUR_INC:  nxt = cursor + 6'd1;
      CUR_LF:   nxt = {row + 2'd1, 4'd0};
      CUR_CR:   nxt = {row, 4'd0};
      CUR_BS:   nxt = (cursor == 6'd0) ? 6'd0
                                       : cursor - 6'd1;
      CUR_HOME: nxt = 6'd0;
      default:  nxt = cursor;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cursor <= 6'd0;
    else     cursor <= nxt;
  end

endmodule

// File: rtl/oled_text_console.sv
// ASCII stream to OLED controller bridge: 4x16 text cursor, control
// characters, screen clear and one deferred refresh per idle burst.
module oled_text_console
  import oled_text_console_pkg::*;
#(
  parameter bit         AUTO_ON        = 1'b1,
  parameter bit         CLEAR_ON_START = 1'b1,
  parameter logic [7:0] FILL_CHAR      = ASCII_SPACE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       write_start,
  output logic [7:0] write_ascii_data,
  output logic [8:0] write_base_addr,
  input  logic       write_ready,
  output logic       update_start,
  input  logic       update_ready,
  output logic       disp_on_start,
  input  logic       disp_on_ready,
  output logic       disp_active,
  output logic [5:0] cursor
);

  state_e     state;
  logic       dirty;
  logic [5:0] clr_idx;
  logic [2:0] cur_op;
  logic       accept;
  logic       wr_ack;
  logic       clr_done;
  logic       on_go;

  // The pulse cycle itself still sees the old ready; skip it.
  assign wr_ack   = write_ready && !write_start;
  assign accept   = in_valid && in_ready;
  assign clr_done = wr_ack && (clr_idx == 6'd63);
  assign on_go    = update_ready &&
                    ((state == S_OFF) ||
                     ((state == S_ON_WAIT) && !disp_on_start));

  always_comb begin
    cur_op = CUR_NONE;
    if ((state == S_IDLE) && accept) begin
      unique case (1'b1)
        is_print(in_data):     cur_op = CUR_INC;
        (in_data == ASCII_LF): cur_op = CUR_LF;
        (in_data == ASCII_CR): cur_op = CUR_CR;
        (in_data == ASCII_BS): cur_op = CUR_BS;
        default:               cur_op = CUR_NONE;
      endcase
    end else if ((state == S_CLR_WAIT) && clr_done) begin
      cur_op = CUR_HOME;
    end
  end

  oled_cursor u_cursor (
    .clk    (clk),
    .rst    (rst),
    .op     (cur_op),
    .cursor (cursor)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_OFF;
      dirty            <= 1'b0;
      clr_idx          <= 6'd0;
      in_ready         <= 1'b0;
      write_start      <= 1'b0;
      write_ascii_data <= 8'd0;
      write_base_addr  <= 9'd0;
      update_start     <= 1'b0;
      disp_on_start    <= 1'b0;
      disp_active      <= 1'b0;
    end else begin
      write_start   <= 1'b0;
      update_start  <= 1'b0;
      disp_on_start <= 1'b0;
      unique case (state)
        S_OFF, S_ON_WAIT: begin
          if (on_go) begin
            clr_idx <= 6'd0;
            if (CLEAR_ON_START) begin
              state <= S_CLR;
            end else begin
              state       <= S_IDLE;
              in_ready    <= 1'b1;
              disp_active <= 1'b1;
            end
          end else if ((state == S_OFF) && disp_on_ready &&
                       (AUTO_ON || in_valid)) begin
            disp_on_start <= 1'b1;
            state         <= S_ON_WAIT;
          end
        end
        S_IDLE: begin
          if (accept) begin
            unique case (1'b1)
              is_print(in_data): begin
                write_ascii_data <= in_data;
                write_base_addr  <= {cursor, 3'b000};
                in_ready         <= 1'b0;
                state            <= S_WR;
              end
              (in_data == ASCII_LF): dirty <= 1'b1;
              (in_data == ASCII_FF): begin
                clr_idx  <= 6'd0;
                in_ready <= 1'b0;
                state    <= S_CLR;
              end
              default: ;
            endcase
          end else if (!in_valid && dirty && update_ready) begin
            update_start <= 1'b1;
            dirty        <= 1'b0;
            in_ready     <= 1'b0;
            state        <= S_UPD_WAIT;
          end
        end
        S_WR: begin
          if (write_ready) begin
            write_start <= 1'b1;
            state       <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (wr_ack) begin
            dirty    <= 1'b1;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        S_CLR: begin
          if (write_ready) begin
            write_start      <= 1'b1;
            write_ascii_data <= FILL_CHAR;
            write_base_addr  <= {clr_idx, 3'b000};
            state            <= S_CLR_WAIT;
          end
        end
        S_CLR_WAIT: begin
          if (clr_done) begin
            dirty       <= 1'b1;
            in_ready    <= 1'b1;
            disp_active <= 1'b1;
            state       <= S_IDLE;
          end else if (wr_ack) begin
            clr_idx <= clr_idx + 6'd1;
            state   <= S_CLR;
          end
        end
        S_UPD_WAIT: begin
          if (update_ready && !update_start) begin
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

endmodule
